// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neuron nodes.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Fixed working widths for the activation helper; callers extend/slice.
  localparam int SAT_ACC_W = 64;
  localparam int SAT_OUT_W = 32;

  // Ceiling log2 for elaboration-time width math.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Index width: a single-input neuron still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Arithmetic shift, then ReLU and saturation to the positive signed range.
  function automatic logic [SAT_OUT_W-1:0] sat_relu(
    input logic signed [SAT_ACC_W-1:0] acc,
    input int                          shift,
    input int                          data_w
  );
    logic signed [SAT_ACC_W-1:0] y;
    logic signed [SAT_ACC_W-1:0] y_max;
    y     = acc >>> shift;
    y_max = (SAT_ACC_W'(1) <<< (data_w - 1)) - SAT_ACC_W'(1);
    if (y[SAT_ACC_W-1])
      return '0;
    else if (y > y_max)
      return y_max[SAT_OUT_W-1:0];
    else
      return y[SAT_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Registered signed multiply-accumulate with a load-bias path.
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  // Full-width signed product; both operands are signed so it sign-extends.
  assign prod = a * w;

  // Accumulator: load has priority so a new vector always starts from bias.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset)
      acc <= '0;
    else if (load)
      acc <= ACC_W'(bias);
    else if (en)
      acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one shared MAC, runtime-writable weights/bias,
// shift + ReLU + saturation, valid/ready on both sides.
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter  int N_IN   = 5,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 20,
  parameter  int SHIFT  = 6,
  localparam int IDX_W  = idx_width(N_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [IDX_W:0]           cfg_addr,
  input  logic [DATA_W-1:0]        cfg_wdata,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data
);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] w_q   [N_IN];
  logic signed [DATA_W-1:0] act_q [N_IN];
  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] a_sel;
  logic signed [DATA_W-1:0] w_sel;
  logic signed [ACC_W-1:0]  acc;
  logic [SAT_OUT_W-1:0]     act_val;
  logic                     accept;
  logic                     mac_en;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign mac_en   = (state == ST_MAC);
  assign act_val  = sat_relu(SAT_ACC_W'(acc), SHIFT, DATA_W);

  // Operand select for the current MAC step.
  always_comb begin
    // NOTE: defaults first so no path leaves the outputs unassigned (no latch).
    a_sel = '0;
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sel = act_q[i];
        w_sel = w_q[i];
      end
    end
  end

  // Weight/bias register file; writes only land while idle.
  always_ff @(posedge clk) begin
    // NOTE: this register file is reset on purpose - a cleared node must compute zero.
    if (reset) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      bias_q  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != ST_IDLE);
      if (cfg_we && state == ST_IDLE) begin
        if (cfg_addr == (IDX_W+1)'(N_IN))
          bias_q <= cfg_wdata;
        for (int i = 0; i < N_IN; i++)
          if (cfg_addr == (IDX_W+1)'(i)) w_q[i] <= cfg_wdata;
      end
    end
  end

  // Activation capture at accept; held for the whole MAC sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) act_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_IN; i++) act_q[i] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Control FSM: IDLE -> MAC (N_IN steps) -> ACT -> OUT -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (idx == IDX_W'(N_IN - 1))
            state <= ST_ACT;
          else
            idx <= idx + 1'b1;
        end
        ST_ACT: begin
          out_data  <= act_val[DATA_W-1:0];
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  nn_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (mac_en),
    .bias  (bias_q),
    .a     (a_sel),
    .w     (w_sel),
    .acc   (acc)
  );

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: a 5-input and a 1-input instance.
module tb_neuron_mac_seq;

  logic        clk = 1'b0;
  logic        reset;
  int          tests = 0;
  int          fails = 0;

  // 5-input instance signals
  logic        cfg_we5, cfg_err5, in_valid5, in_ready5, out_valid5, out_ready5;
  logic [3:0]  cfg_addr5;
  logic [7:0]  cfg_wdata5, out_data5;
  logic [39:0] in_data5;

  // 1-input instance signals
  logic        cfg_we1, cfg_err1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [1:0]  cfg_addr1;
  logic [7:0]  cfg_wdata1, out_data1, in_data1;

  always #5 clk = ~clk;

  neuron_mac_seq #(.N_IN(5)) dut5 (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we5), .cfg_addr(cfg_addr5), .cfg_wdata(cfg_wdata5), .cfg_err(cfg_err5),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5)
  );

  neuron_mac_seq #(.N_IN(1)) dut1 (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we1), .cfg_addr(cfg_addr1), .cfg_wdata(cfg_wdata1), .cfg_err(cfg_err1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write5(input logic [3:0] addr, input logic signed [7:0] data);
    cfg_we5 = 1'b1; cfg_addr5 = addr; cfg_wdata5 = data;
    @(posedge clk); #1;
    cfg_we5 = 1'b0;
  endtask

  // Drive one vector; the accept edge is the next rising edge.
  task automatic accept5(input string tag, input logic signed [7:0] a0, a1, a2, a3, a4);
    check({tag, "_ready_before"}, in_ready5, 1);
    in_data5  = {a4, a3, a2, a1, a0};
    in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    in_data5  = '1;
    check({tag, "_ready_after"}, in_ready5, 0);
  endtask

  // Wait (bounded) for out_valid; elapsed = edges already seen since accept.
  task automatic wait_out5(input string tag, input int elapsed, input int exp_lat,
                           input int exp_acc, input int exp_out);
    int  n;
    bit  seen;
    n    = elapsed;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid5) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_acc"}, dut5.u_mac.acc, exp_acc);
    check({tag, "_out"}, out_data5, exp_out);
  endtask

  task automatic pop5(input string tag);
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    out_ready5 = 1'b0;
    check({tag, "_pop_valid"}, out_valid5, 0);
    check({tag, "_pop_ready"}, in_ready5, 1);
  endtask

  initial begin
    reset = 1'b1;
    cfg_we5 = 0; cfg_addr5 = 0; cfg_wdata5 = 0; in_valid5 = 0; in_data5 = 0; out_ready5 = 0;
    cfg_we1 = 0; cfg_addr1 = 0; cfg_wdata1 = 0; in_valid1 = 0; in_data1 = 0; out_ready1 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready5, 1);
    check("rst_out_valid", out_valid5, 0);
    check("rst_out_data", out_data5, 0);
    check("rst_cfg_err", cfg_err5, 0);

    // Load default weights and bias
    write5(4'd0, -8'sd19);
    write5(4'd1, 8'sd69);
    write5(4'd2, 8'sd104);
    write5(4'd3, -8'sd119);
    write5(4'd4, -8'sd69);
    write5(4'd5, -8'sd7);

    // Vector 1: acc 4303 -> 67
    accept5("v1", 10, 20, 30, 0, 0);
    wait_out5("v1", 0, 6, 4303, 67);
    pop5("v1");

    // Vector 2: all 64 -> acc -2183 -> ReLU 0
    accept5("v2", 64, 64, 64, 64, 64);
    wait_out5("v2", 0, 6, -2183, 0);
    pop5("v2");

    // Vector 3: saturation, 13201 >>> 6 = 206 -> 127
    accept5("v3", 0, 0, 127, 0, 0);
    wait_out5("v3", 0, 6, 13201, 127);
    pop5("v3");

    // Backpressure: hold out_ready low for 10 cycles
    accept5("bp", 10, 20, 30, 0, 0);
    wait_out5("bp", 0, 6, 4303, 67);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data5, 67);
      check("bp_hold_valid", out_valid5, 1);
      check("bp_hold_in_ready", in_ready5, 0);
    end
    pop5("bp");
    accept5("bp_next", 64, 64, 64, 64, 64);
    wait_out5("bp_next", 0, 6, -2183, 0);
    pop5("bp_next");

    // Config write during MAC is dropped and flagged for one cycle
    accept5("busy", 10, 20, 30, 0, 0);
    cfg_we5 = 1'b1; cfg_addr5 = 4'd2; cfg_wdata5 = 8'd0;
    @(posedge clk); #1;
    cfg_we5 = 1'b0;
    check("busy_err_pulse", cfg_err5, 1);
    @(posedge clk); #1;
    check("busy_err_clear", cfg_err5, 0);
    wait_out5("busy", 2, 6, 4303, 67);
    pop5("busy");
    accept5("readback", 10, 20, 30, 0, 0);
    wait_out5("readback", 0, 6, 4303, 67);
    pop5("readback");

    // Reset mid-MAC aborts and clears weights
    accept5("abort", 10, 20, 30, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out_valid", out_valid5, 0);
    check("abort_in_ready", in_ready5, 1);
    check("abort_out_data", out_data5, 0);
    accept5("zeroed", 10, 20, 30, 0, 0);
    wait_out5("zeroed", 0, 6, 0, 0);
    pop5("zeroed");

    // Out-of-range addresses ignored; write coinciding with accept
    write5(4'd0, 8'sd1);
    write5(4'd5, 8'sd64);
    write5(4'd6, 8'sd100);
    write5(4'd7, 8'sd100);
    check("oor_no_err", cfg_err5, 0);
    cfg_we5 = 1'b1; cfg_addr5 = 4'd5; cfg_wdata5 = 8'd0;
    accept5("old_bias", 64, 0, 0, 0, 0);
    cfg_we5 = 1'b0;
    check("idle_write_no_err", cfg_err5, 0);
    wait_out5("old_bias", 0, 6, 128, 2);
    pop5("old_bias");
    accept5("new_bias", 64, 0, 0, 0, 0);
    wait_out5("new_bias", 0, 6, 64, 1);
    pop5("new_bias");
    cfg_we5 = 1'b1; cfg_addr5 = 4'd0; cfg_wdata5 = 8'sd3;
    accept5("new_weight", 64, 0, 0, 0, 0);
    cfg_we5 = 1'b0;
    wait_out5("new_weight", 0, 6, 192, 3);
    pop5("new_weight");

    // Single-input instance: W0=2, bias=0, A=127 -> acc 254 -> 3, latency 2
    cfg_we1 = 1'b1; cfg_addr1 = 2'd0; cfg_wdata1 = 8'sd2;
    @(posedge clk); #1;
    cfg_addr1 = 2'd1; cfg_wdata1 = 8'sd0;
    @(posedge clk); #1;
    cfg_we1 = 1'b0;
    check("n1_ready", in_ready1, 1);
    in_data1 = 8'sd127; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    begin
      int  n;
      bit  seen;
      n = 0; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk); #1;
        n++;
        if (out_valid1) seen = 1'b1;
      end
      check("n1_seen", seen, 1);
      check("n1_latency", n, 2);
      check("n1_acc", dut1.u_mac.acc, 254);
      check("n1_out", out_data1, 3);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("n1_pop_valid", out_valid1, 0);
    check("n1_pop_ready", in_ready1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
